// File: rtl/div_pkg.sv
// div_pkg -- shared constants and state encoding for the restoring divider.
//   OP_W   : operand width (dividend, divisor, quotient, remainder)
//   ITERS  : number of restoring steps per division
//   state_t: FSM state encoding used by div
package div_pkg;
    localparam int OP_W  = 16;
    localparam int ITERS = 16;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_START1 = 3'd1,
        ST_ITER   = 3'd2,
        ST_FIX    = 3'd3,
        ST_END    = 3'd4
    } state_t;
endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division step.
//   i_rem : current partial remainder
//   i_dvs : divisor
//   i_bit : next dividend bit (MSB first)
//   o_rem : partial remainder after the step
//   o_q   : quotient bit produced by the step
module div_step
    import div_pkg::*;
(
    input  logic [OP_W-1:0] i_rem,
    input  logic [OP_W-1:0] i_dvs,
    input  logic            i_bit,
    output logic [OP_W-1:0] o_rem,
    output logic            o_q
);
    logic [OP_W:0]   w_sh;
    logic [OP_W-1:0] w_diff;

    assign w_sh   = {i_rem, i_bit};
    // Full 17-bit compare; the subtraction only needs the low bits because
    // whenever it is taken the difference is smaller than the divisor.
    assign o_q    = (w_sh >= {1'b0, i_dvs});
    assign w_diff = w_sh[OP_W-1:0] - i_dvs;
    assign o_rem  = o_q ? w_diff : w_sh[OP_W-1:0];
endmodule

// File: rtl/div.sv
// div -- multi-cycle restoring divider, fixed 18-edge latency after init.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   init     : start request, honoured only in START
//   op_A     : dividend, captured in START1
//   op_B     : divisor, captured in START1
//   done     : high for DONE_HOLD cycles while the result is valid
//   result   : {remainder, quotient}, held until the next START1
//   div_zero : last operation had a zero divisor
// Macro DIV_SIGNED_EN: two's-complement operands (truncating division).
// Without it all arithmetic is unsigned and no sign logic exists.
module div
    import div_pkg::*;
#(
    parameter int DONE_HOLD = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [OP_W-1:0]   op_A,
    input  logic [OP_W-1:0]   op_B,
    output logic              done,
    output logic [2*OP_W-1:0] result,
    output logic              div_zero
);
    // Counter is shared by the iteration loop and the END hold window.
    localparam int CMAX = (DONE_HOLD > ITERS) ? DONE_HOLD : ITERS;
    localparam int CW   = $clog2(CMAX) + 1;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [OP_W-1:0] r_q;    // dividend bits shift out, quotient bits shift in
    logic [OP_W-1:0] r_rem;
    logic [OP_W-1:0] r_dvs;
    logic [OP_W-1:0] w_rem;
    logic            w_qbit;
    logic            w_iter_last;
    logic            w_hold_last;

`ifdef DIV_SIGNED_EN
    logic            r_a_neg;
    logic            r_b_neg;
    logic [OP_W-1:0] r_a_raw;
`endif

    assign w_iter_last = (r_cnt == CW'(ITERS - 1));
    assign w_hold_last = (r_cnt == CW'(DONE_HOLD - 1));

    div_step u_step (
        .i_rem (r_rem),
        .i_dvs (r_dvs),
        .i_bit (r_q[OP_W-1]),
        .o_rem (w_rem),
        .o_q   (w_qbit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_START;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_START:  if (init) w_next = ST_START1;
            ST_START1: w_next = ST_ITER;
            ST_ITER:   if (w_iter_last) w_next = ST_FIX;
            ST_FIX:    w_next = ST_END;
            ST_END:    if (w_hold_last) w_next = ST_START;
            default:   w_next = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            done     <= 1'b0;
            result   <= '0;
            div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_a_raw  <= '0;
`endif
        end else begin
            case (r_state)
                ST_START: begin
                    r_cnt <= '0;
                    done  <= 1'b0;
                end
                ST_START1: begin
`ifdef DIV_SIGNED_EN
                    r_a_neg <= op_A[OP_W-1];
                    r_b_neg <= op_B[OP_W-1];
                    r_a_raw <= op_A;
                    r_q     <= op_A[OP_W-1] ? (~op_A + OP_W'(1)) : op_A;
                    r_dvs   <= op_B[OP_W-1] ? (~op_B + OP_W'(1)) : op_B;
`else
                    r_q     <= op_A;
                    r_dvs   <= op_B;
`endif
                    r_rem    <= '0;
                    r_cnt    <= '0;
                    result   <= '0;
                    div_zero <= 1'b0;
                end
                ST_ITER: begin
                    r_rem <= w_rem;
                    r_q   <= {r_q[OP_W-2:0], w_qbit};
                    r_cnt <= r_cnt + CW'(1);
                end
                ST_FIX: begin
                    done     <= 1'b1;
                    r_cnt    <= '0;
                    div_zero <= (r_dvs == '0);
`ifdef DIV_SIGNED_EN
                    // Zero divisor reports the raw dividend, not its magnitude.
                    if (r_dvs == '0)
                        result <= {r_a_raw, {OP_W{1'b1}}};
                    else
                        result <= {r_a_neg ? (~r_rem + OP_W'(1)) : r_rem,
                                   (r_a_neg ^ r_b_neg) ? (~r_q + OP_W'(1)) : r_q};
`else
                    // Unsigned restoring with divisor 0 naturally yields
                    // quotient all-ones and remainder = dividend.
                    result <= {r_rem, r_q};
`endif
                end
                ST_END: begin
                    if (w_hold_last) begin
                        done  <= 1'b0;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    done  <= 1'b0;
                    r_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// tb_div -- directed self-checking bench for div.
// Latency is counted as: edge E0 samples init=1, done must be low after
// edge E0+17 and high after edge E0+18.
module tb_div;
    localparam int DH = 30;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        init  = 1'b0;
    logic [15:0] op_A  = '0;
    logic [15:0] op_B  = '0;
    logic        done;
    logic        div_zero;
    logic [31:0] result;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    div #(.DONE_HOLD(DH)) dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .op_A     (op_A),
        .op_B     (op_B),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge while the DUT sits in START; returns at the
    // negedge after the edge where done must first be high.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input logic dz, input logic hold);
        op_A = a;
        op_B = b;
        init = 1'b1;
        cyc();                       // E0 samples init
        if (!hold) init = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            cyc();
            if (k == 1) begin        // operands already captured
                op_A = 16'($urandom);
                op_B = 16'($urandom);
            end
            if (k == 17) chk({tag, "/done_early"}, 32'(done), 32'd0);
        end
        chk({tag, "/done"},   32'(done),     32'd1);
        chk({tag, "/result"}, result,        exp);
        chk({tag, "/dz"},     32'(div_zero), 32'(dz));
    endtask

    // Walk the rest of END; optionally pulse init mid-END.
    task automatic finish_end(input string tag, input logic [31:0] exp, input logic dz,
                              input logic poke);
        for (int i = 1; i < DH; i++) begin
            cyc();
            if (poke) init = (i == 3);
        end
        chk({tag, "/done_last_end"}, 32'(done), 32'd1);
        cyc();
        chk({tag, "/done_start"}, 32'(done),     32'd0);
        chk({tag, "/hold_res"},   result,        exp);
        chk({tag, "/hold_dz"},    32'(div_zero), 32'(dz));
    endtask

    task automatic idle(input string tag, input int n);
        repeat (n) cyc();
        chk({tag, "/idle_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst/done",   32'(done),     32'd0);
        chk("rst/result", result,        32'd0);
        chk("rst/dz",     32'(div_zero), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle("post_rst", 3);

        run_op("100/7", 16'd100, 16'd7, 32'h0002000E, 1'b0, 1'b0);
        finish_end("100/7", 32'h0002000E, 1'b0, 1'b0);

        run_op("FFFF/1", 16'hFFFF, 16'd1, 32'h0000FFFF, 1'b0, 1'b0);
        finish_end("FFFF/1", 32'h0000FFFF, 1'b0, 1'b0);

        // init pulse inside END must not start anything
        run_op("5/9", 16'd5, 16'd9, 32'h00050000, 1'b0, 1'b0);
        finish_end("5/9", 32'h00050000, 1'b0, 1'b1);
        init = 1'b0;
        idle("end_poke", 25);

        run_op("1234/0", 16'd1234, 16'd0, 32'h04D2FFFF, 1'b1, 1'b0);
        finish_end("1234/0", 32'h04D2FFFF, 1'b1, 1'b0);

        // Async reset while a nonzero result is held in END
        run_op("10/5", 16'd10, 16'd5, 32'h00000002, 1'b0, 1'b0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_end/done",   32'(done), 32'd0);
        chk("rst_end/result", result,    32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Async reset at the 8th ITER cycle of 100/7
        op_A = 16'd100;
        op_B = 16'd7;
        init = 1'b1;
        cyc();
        init = 1'b0;
        for (int k = 1; k <= 8; k++) cyc();
        reset = 1'b0;
        #1;
        chk("rst_iter/done",   32'(done), 32'd0);
        chk("rst_iter/result", result,    32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle("rst_iter_noinit", 25);
        chk("rst_iter/res_idle", result, 32'd0);
        run_op("100/7b", 16'd100, 16'd7, 32'h0002000E, 1'b0, 1'b0);
        finish_end("100/7b", 32'h0002000E, 1'b0, 1'b0);

        // init held high: back-to-back operations with one START cycle
        run_op("hold1", 16'd100, 16'd7, 32'h0002000E, 1'b0, 1'b1);
        finish_end("hold1", 32'h0002000E, 1'b0, 1'b0);
        run_op("hold2", 16'd200, 16'd3, 32'h00020042, 1'b0, 1'b1);
        init = 1'b0;
        finish_end("hold2", 32'h00020042, 1'b0, 1'b0);

`ifdef DIV_SIGNED_EN
        run_op("-7/2", 16'hFFF9, 16'd2, 32'hFFFFFFFD, 1'b0, 1'b0);
        finish_end("-7/2", 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("7/-2", 16'd7, 16'hFFFE, 32'h0001FFFD, 1'b0, 1'b0);
        finish_end("7/-2", 32'h0001FFFD, 1'b0, 1'b0);
        run_op("min/-1", 16'h8000, 16'hFFFF, 32'h00008000, 1'b0, 1'b0);
        finish_end("min/-1", 32'h00008000, 1'b0, 1'b0);
        run_op("-5/0", 16'hFFFB, 16'd0, 32'hFFFBFFFF, 1'b1, 1'b0);
        finish_end("-5/0", 32'hFFFBFFFF, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
